nco_sine_gen: RTL and testbench
===============================

Name: nco_sine_gen

Overview:
- Parametrised numerically-controlled sine source; successor to the fixed 32-entry sine lookup.
- Phase accumulator with programmable frequency word and phase preload. Quarter-wave ROM lookup.
- Selectable waveform mode and amplitude attenuation.
- Registered output with valid/ready handshake, feeding the DAC/modulator chain in the transmitter datapath.

Parameters:
- PHASE_W, 16, phase accumulator width (8..32).
- LUT_DEPTH, 32, samples per period seen by the index. Power of 2, 8..256.
- OFFSET, 8'h10, DC offset added to every output sample.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- en  input  1  generator enable
- freq_word  input  PHASE_W  phase increment per produced sample
- phase_load  input  1  load phase_init into accumulator, flush output
- phase_init  input  PHASE_W  preload phase value
- mode  input  2  0 sine, 1 cosine, 2 square, 3 DC midscale
- amp_shift  input  2  attenuation, arithmetic right shift of signed swing
- out_data  output  8  sample
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts sample
- out_wrap  output  1  qualifies out_data: accumulator wrapped on the advance that produced this sample

Behaviour:
- Clock, reset and priority:
  - Single clock domain: clk. Synchronous active-low reset: rst_n.
  - Reset takes effect on the clk edge with rst_n=0: phase=0, out_data=0, out_valid=0, out_wrap=0.
  - Priority per edge: reset > phase_load > advance > consume.
- Index and signed swing:
  - WIDTH = log2(LUT_DEPTH). idx = phase[PHASE_W-1 -: WIDTH].
  - Internal quarter-wave ROM has 65 entries: q[k] = round_half_away(64*sin(2*pi*k/256)), k=0..64, so q[64]=64.
  - Full-wave position p = (idx << (8-WIDTH)), 8 bits. The signed swing s(p) is derived from q by quarter symmetry:
    - p<64: +q[p]
    - 64..127: +q[128-p]
    - 128..191: -q[p-128]
    - 192..255: -q[256-p]
- Sample value per mode:
  - mode 0: OFFSET + 64 + (s(p) >>> amp_shift)
  - mode 1: same formula with p replaced by p+64 mod 256
  - mode 2: OFFSET + 64 + (64 >>> amp_shift) if p<128, else OFFSET + 64 - (64 >>> amp_shift)
  - mode 3: OFFSET + 64
  - Result is exactly 8 bits with no overflow for OFFSET <= 8'h7F.
- For LUT_DEPTH=32, sine mode with amp_shift=0 must reproduce the legacy table exactly: 0x50,0x5C,0x68,0x74,0x7D,0x85,0x8B,0x8F,0x90, ... down to 0x10 at index 24.
- Advance condition: advance = en && !phase_load && (!out_valid || out_ready). On advance:
  - out_data <= sample(phase, mode, amp_shift), computed from the current phase before update.
  - phase <= phase + freq_word, mod 2^PHASE_W.
  - out_wrap <= carry-out of that add.
  - out_valid <= 1.
- Latency: one cycle from an accepted advance to the sample appearing on out_data.
- Consume: if no advance, out_valid && out_ready, then out_valid <= 0. out_data and out_wrap hold.
- Stall: out_valid && !out_ready holds out_data, out_wrap and phase unchanged, regardless of en, mode, freq_word and amp_shift changes.
- phase_load: phase <= phase_init, out_valid <= 0, out_wrap <= 0, out_data holds. The pending sample is discarded even if out_ready is high the same cycle.
- en=0: no advance; a pending valid sample remains until consumed.
- freq_word=0: constant output at the current phase; out_wrap is never set.
- mode, amp_shift and freq_word are sampled only on advance edges. No glitch within a held sample.

Test Plan:
- Reset, en=1, out_ready=1, LUT_DEPTH=32, freq_word=16'h0800, mode 0:
  - out_valid rises 1 cycle after the first enabled edge.
  - out_data follows 0x50,0x5C,0x68,0x74,0x7D,0x85,0x8B,0x8F,0x90,0x8F, ...
  - Minimum 0x10 at sample 24. out_wrap=1 only on sample 31, then the sequence repeats.
- Same setup, mode 1: first sample 0x90, sample 8 = 0x50, sample 16 = 0x10. Mode 2: samples 0..15 = 0x90, samples 16..31 = 0x10.
- Mode 0, amp_shift=2: peak 0x60 at index 8, trough 0x40 at index 24, centre 0x50.
- Backpressure: drop out_ready for 3 cycles mid-stream.
  - out_data and out_valid hold.
  - No sample is lost or duplicated after release: checker compares against the ideal index sequence.
- phase_load with phase_init=16'h4000 while out_valid=1 and out_ready=1: out_valid=0 next cycle; the next sample is 0x90 (index 8).
- Reset mid-stream, rst_n low for 1 edge: all outputs 0 at the following edge. Restart reproduces the first sequence from 0x50.

Source files
------------

// File: rtl/nco_sine_gen.sv
// Purpose : NCO sine source; phase accumulator, quarter-wave ROM, waveform mode and attenuation select.
// Latency : one cycle from an accepted advance to the sample on out_data.
// Backpressure: out_valid && !out_ready freezes phase, out_data and out_wrap; phase_load flushes.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   en              generator enable
//   freq_word       phase increment per produced sample
//   phase_load      load phase_init into the accumulator and discard any pending sample
//   phase_init      preload phase value
//   mode            0 sine, 1 cosine, 2 square, 3 DC midscale
//   amp_shift       arithmetic right shift applied to the signed swing
//   out_data        8-bit sample, qualified by out_valid, accepted with out_ready
//   out_wrap        accumulator carried out on the advance that produced out_data
module nco_sine_gen #(
    parameter int          PHASE_W   = 16,
    parameter int          LUT_DEPTH = 32,
    parameter logic [7:0]  OFFSET    = 8'h10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [PHASE_W-1:0] freq_word,
    input  logic               phase_load,
    input  logic [PHASE_W-1:0] phase_init,
    input  logic [1:0]         mode,
    input  logic [1:0]         amp_shift,
    output logic [7:0]         out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_wrap
);

    localparam int WIDTH = $clog2(LUT_DEPTH);

    // round(64*sin(2*pi*k/256)), k = 0..64; entry 64 is the peak.
    localparam logic [6:0] QROM [0:64] = '{
        7'd0,  7'd2,  7'd3,  7'd5,  7'd6,  7'd8,  7'd9,  7'd11,
        7'd12, 7'd14, 7'd16, 7'd17, 7'd19, 7'd20, 7'd22, 7'd23,
        7'd24, 7'd26, 7'd27, 7'd29, 7'd30, 7'd32, 7'd33, 7'd34,
        7'd36, 7'd37, 7'd38, 7'd39, 7'd41, 7'd42, 7'd43, 7'd44,
        7'd45, 7'd46, 7'd47, 7'd48, 7'd49, 7'd50, 7'd51, 7'd52,
        7'd53, 7'd54, 7'd55, 7'd56, 7'd56, 7'd57, 7'd58, 7'd59,
        7'd59, 7'd60, 7'd60, 7'd61, 7'd61, 7'd62, 7'd62, 7'd62,
        7'd63, 7'd63, 7'd63, 7'd64, 7'd64, 7'd64, 7'd64, 7'd64,
        7'd64
    };

    logic [PHASE_W-1:0] phase;
    logic [PHASE_W:0]   phase_sum;
    logic               advance;

    logic [WIDTH-1:0]   idx;
    logic [7:0]         pos;
    logic [7:0]         pos_sel;
    logic [6:0]         qidx;
    logic [7:0]         mag;
    logic signed [7:0]  swing;
    logic signed [7:0]  scaled;
    logic [7:0]         sample;

    assign phase_sum = {1'b0, phase} + {1'b0, freq_word};
    assign advance   = en && !phase_load && (!out_valid || out_ready);

    always_comb begin
        idx     = phase[PHASE_W-1 -: WIDTH];
        // Scale the index onto the 256-point full-wave grid.
        pos     = 8'(idx) << (8 - WIDTH);
        // Cosine is sine a quarter period ahead.
        pos_sel = (mode == 2'd1) ? (pos + 8'd64) : pos;
        // Odd quadrants read the ROM mirrored; entry 64 covers the peak.
        qidx    = pos_sel[6] ? (7'd64 - {1'b0, pos_sel[5:0]}) : {1'b0, pos_sel[5:0]};
        mag     = {1'b0, QROM[qidx]};
        case (mode)
            2'd0, 2'd1: swing = pos_sel[7] ? (8'd0 - mag) : mag;
            2'd2:       swing = pos[7] ? -8'sd64 : 8'sd64;
            default:    swing = 8'sd0;
        endcase
        scaled  = swing >>> amp_shift;
        // Modular 8-bit add; the true result always fits for OFFSET <= 8'h7F.
        sample  = OFFSET + 8'd64 + scaled;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_wrap  <= 1'b0;
        end else if (phase_load) begin
            phase     <= phase_init;
            out_valid <= 1'b0;
            out_wrap  <= 1'b0;
        end else if (advance) begin
            out_data  <= sample;
            phase     <= phase_sum[PHASE_W-1:0];
            out_wrap  <= phase_sum[PHASE_W];
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nco_sine_gen.sv
module tb_nco_sine_gen;

    localparam int  PHASE_W = 16;
    localparam int  IDX_W   = 5;
    localparam real PI      = 3.14159265358979;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [15:0]  freq_word;
    logic         phase_load;
    logic [15:0]  phase_init;
    logic [1:0]   mode;
    logic [1:0]   amp_shift;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_wrap;

    int tests = 0;
    int fails = 0;

    logic [7:0] got_d[$];
    logic       got_w[$];

    nco_sine_gen #(.PHASE_W(16), .LUT_DEPTH(32), .OFFSET(8'h10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .freq_word  (freq_word),
        .phase_load (phase_load),
        .phase_init (phase_init),
        .mode       (mode),
        .amp_shift  (amp_shift),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_wrap   (out_wrap)
    );

    always #5 clk = ~clk;

    // Reference: ideal sine with the rounding rule, evaluated on the full-wave grid.
    function automatic int qv(int k);
        real x;
        x = 64.0 * $sin(2.0 * PI * k / 256.0);
        return int'(x);
    endfunction

    function automatic int swing_of(int p_in);
        int p;
        p = p_in % 256;
        if (p < 64)       return qv(p);
        else if (p < 128) return qv(128 - p);
        else if (p < 192) return -qv(p - 128);
        else              return -qv(256 - p);
    endfunction

    function automatic int exp_sample(int ph, int md, int amp);
        int p;
        int s;
        p = (ph >> (PHASE_W - IDX_W)) << (8 - IDX_W);
        case (md)
            0:       s = swing_of(p) >>> amp;
            1:       s = swing_of(p + 64) >>> amp;
            2:       s = (p < 128) ? (64 >>> amp) : -(64 >>> amp);
            default: s = 0;
        endcase
        return (16 + 64 + s) & 255;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_phase(input int init);
        phase_load = 1'b1;
        phase_init = 16'(init);
        tick();
        check("load_flush_valid", 32'(out_valid), 32'd0);
        phase_load = 1'b0;
    endtask

    // Stream scoreboard: every accepted sample must be the next one of the
    // ideal sequence init + n*fw; a stalled sample must hold unchanged.
    // pmode 0: always ready, 1: three-cycle drop, 2: random ready with
    // control inputs scrambled while stalled.
    task automatic run_stream(input int init, input int fw, input int md, input int amp,
                              input int nsamp, input int pmode);
        int n = 0;
        int cyc = 0;
        int ph;
        bit r;
        bit stalled;
        logic [7:0] hd;
        logic       hw;
        got_d.delete();
        got_w.delete();
        freq_word = 16'(fw);
        mode      = 2'(md);
        amp_shift = 2'(amp);
        en        = 1'b1;
        while (n < nsamp && cyc < nsamp * 4 + 20) begin
            case (pmode)
                0:       r = 1'b1;
                1:       r = !(cyc >= 5 && cyc < 8);
                default: r = ($urandom_range(0, 2) != 0);
            endcase
            out_ready = r;
            if (out_valid && r) begin
                ph = (init + n * fw) & 32'hFFFF;
                check("sample", 32'(out_data), 32'(exp_sample(ph, md, amp)));
                check("wrap", 32'(out_wrap), ((ph + fw) > 65535) ? 32'd1 : 32'd0);
                got_d.push_back(out_data);
                got_w.push_back(out_wrap);
                n++;
            end
            stalled = out_valid && !r;
            hd = out_data;
            hw = out_wrap;
            if (stalled && pmode == 2) begin
                en        = 1'($urandom_range(0, 1));
                mode      = 2'($urandom_range(0, 3));
                amp_shift = 2'($urandom_range(0, 3));
                freq_word = 16'($urandom);
            end else begin
                en        = 1'b1;
                mode      = 2'(md);
                amp_shift = 2'(amp);
                freq_word = 16'(fw);
            end
            tick();
            cyc++;
            if (stalled) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", 32'(out_data), 32'(hd));
                check("stall_wrap", 32'(out_wrap), 32'(hw));
            end
        end
        en        = 1'b1;
        mode      = 2'(md);
        amp_shift = 2'(amp);
        freq_word = 16'(fw);
        if (n < nsamp) check("stream_budget", 32'(n), 32'(nsamp));
    endtask

    initial begin
        logic [7:0] held;
        int init;
        int fw;

        // Reset state.
        rst_n = 1'b0; en = 1'b0; freq_word = 16'h0800; phase_load = 1'b0;
        phase_init = 16'h0000; mode = 2'd0; amp_shift = 2'd0; out_ready = 1'b1;
        tick();
        tick();
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_wrap", 32'(out_wrap), 32'd0);

        // Legacy sine sequence, first sample one cycle after the first enabled edge.
        rst_n = 1'b1;
        en    = 1'b1;
        tick();
        check("first_valid", 32'(out_valid), 32'd1);
        check("first_data", 32'(out_data), 32'h50);
        run_stream(0, 16'h0800, 0, 0, 64, 0);
        if (got_d.size() == 64) begin
            check("legacy_s1", 32'(got_d[1]), 32'h5C);
            check("legacy_s4", 32'(got_d[4]), 32'h7D);
            check("legacy_peak", 32'(got_d[8]), 32'h90);
            check("legacy_s9", 32'(got_d[9]), 32'h8F);
            check("legacy_trough", 32'(got_d[24]), 32'h10);
            check("legacy_wrap30", 32'(got_w[30]), 32'd0);
            check("legacy_wrap31", 32'(got_w[31]), 32'd1);
            check("legacy_repeat", 32'(got_d[32]), 32'h50);
            check("legacy_wrap63", 32'(got_w[63]), 32'd1);
        end else check("legacy_count", 32'(got_d.size()), 32'd64);

        // Cosine.
        load_phase(0);
        run_stream(0, 16'h0800, 1, 0, 32, 0);
        if (got_d.size() == 32) begin
            check("cos_s0", 32'(got_d[0]), 32'h90);
            check("cos_s8", 32'(got_d[8]), 32'h50);
            check("cos_s16", 32'(got_d[16]), 32'h10);
        end else check("cos_count", 32'(got_d.size()), 32'd32);

        // Square.
        load_phase(0);
        run_stream(0, 16'h0800, 2, 0, 32, 0);
        if (got_d.size() == 32) begin
            check("sq_s0", 32'(got_d[0]), 32'h90);
            check("sq_s15", 32'(got_d[15]), 32'h90);
            check("sq_s16", 32'(got_d[16]), 32'h10);
            check("sq_s31", 32'(got_d[31]), 32'h10);
        end else check("sq_count", 32'(got_d.size()), 32'd32);

        // Attenuated sine.
        load_phase(0);
        run_stream(0, 16'h0800, 0, 2, 32, 0);
        if (got_d.size() == 32) begin
            check("amp2_centre", 32'(got_d[0]), 32'h50);
            check("amp2_peak", 32'(got_d[8]), 32'h60);
            check("amp2_trough", 32'(got_d[24]), 32'h40);
        end else check("amp2_count", 32'(got_d.size()), 32'd32);

        // DC midscale and three-cycle backpressure mid-stream.
        load_phase(0);
        run_stream(0, 16'h0800, 3, 0, 8, 0);
        load_phase(0);
        run_stream(0, 16'h0800, 0, 0, 20, 1);

        // phase_load while a sample is pending and ready is high.
        check("pre_load_valid", 32'(out_valid), 32'd1);
        held       = out_data;
        out_ready  = 1'b1;
        phase_load = 1'b1;
        phase_init = 16'h4000;
        tick();
        check("load_valid", 32'(out_valid), 32'd0);
        check("load_data_hold", 32'(out_data), 32'(held));
        check("load_wrap", 32'(out_wrap), 32'd0);
        phase_load = 1'b0;
        tick();
        check("load_next_valid", 32'(out_valid), 32'd1);
        check("load_next_data", 32'(out_data), 32'h90);

        // Reset mid-stream, then restart.
        rst_n = 1'b0;
        tick();
        check("mid_rst_data", 32'(out_data), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_wrap", 32'(out_wrap), 32'd0);
        rst_n = 1'b1;
        run_stream(0, 16'h0800, 0, 0, 32, 0);
        if (got_d.size() == 32) begin
            check("restart_s0", 32'(got_d[0]), 32'h50);
            check("restart_s24", 32'(got_d[24]), 32'h10);
        end else check("restart_count", 32'(got_d.size()), 32'd32);

        // Randomised streams with random backpressure; the first uses freq_word=0.
        for (int k = 0; k < 8; k++) begin
            init = int'($urandom_range(0, 65535));
            fw   = (k == 0) ? 0 : int'($urandom_range(1, 65535));
            load_phase(init);
            run_stream(init, fw, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 40, 2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
